// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage.
//   instruction_type : 32-bit RISC-V instruction word
//   NOP_INSTR        : addi x0,x0,0, shown to decode when the queue is empty
//   fetch_entry_t    : one queue entry, instruction plus the PC it came from
package common;

  typedef logic [31:0] instruction_type;

  localparam instruction_type NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    instruction_type instr;
    logic [31:0]     pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empty the queue at the end of this cycle (wins over push/pop)
//   push, push_data : write an entry
//   pop             : drop the head entry
//   count           : current occupancy
//   head            : entry at the head (undefined when count==0)
// Parameter DEPTH (2..8).
import common::*;

module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch feeding decode.
// Holds the fetch PC, issues word requests to a 1-cycle-latency instruction
// memory, queues responses with their PC, and restarts on redirect.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   imem_req, imem_addr             : request to instruction memory
//   imem_rvalid, imem_rdata         : response to last cycle's request
//   instr_valid, instr_ready        : handshake to decode
//   instruction, pc_out             : queue head (NOP / 0 when empty)
//   redirect_valid, redirect_target : flush and restart fetch
//   fetch_fault, fault_pc           : held misaligned redirect
// Build option FETCH_MISALIGN_CHECK_EN: when defined, a misaligned redirect
// halts fetch and raises fetch_fault; otherwise target[1:0] is forced to 00.
import common::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output instruction_type instruction,
  output logic [31:0]     pc_out,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_target,
  output logic            fetch_fault,
  output logic [31:0]     fault_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   last_addr_q, last_addr_d;
  logic          rsp_pending_q, rsp_pending_d;
  logic          push, pop, flush;
  logic [CW:0]   occ_next;
  logic [31:0]   redir_addr;
  logic          redir_ok;
  logic          halted;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  push_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  assign redir_ok    = (redirect_target[1:0] == 2'b00);
  assign halted      = fault_q;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^redirect_target[1:0];
  assign redir_ok    = 1'b1;
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;
  assign fault_pc    = 32'h0;
`endif

  assign redir_addr = {redirect_target[31:2], 2'b00};

  // Only responses to a request we actually issued are accepted; this drops
  // stray responses in and just after reset.
  assign push  = imem_rvalid && rsp_pending_q && !redirect_valid;
  assign pop   = instr_valid && instr_ready && !redirect_valid;
  assign flush = redirect_valid;
  assign occ_next  = {1'b0, q_count} + (CW + 1)'(push) - (CW + 1)'(pop);
  assign push_data = '{instr: imem_rdata, pc: last_addr_q};

  always_comb begin
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    pc_d          = pc_q;
    last_addr_d   = last_addr_q;
    rsp_pending_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
`endif
    if (reset) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      if (redir_ok) begin
        imem_req      = 1'b1;
        imem_addr     = redir_addr;
        pc_d          = redir_addr + 32'd4;
        last_addr_d   = redir_addr;
        rsp_pending_d = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d    = 1'b0;
        fault_pc_d = 32'h0;
      end else begin
        fault_d    = 1'b1;
        fault_pc_d = redirect_target;
`endif
      end
    end else if (occ_next < DEPTH_L && !halted) begin
      imem_req      = 1'b1;
      pc_d          = pc_q + 32'd4;
      last_addr_d   = pc_q;
      rsp_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      last_addr_q   <= RESET_PC;
      rsp_pending_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      last_addr_q   <= last_addr_d;
      rsp_pending_q <= rsp_pending_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end
`endif

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (q_count),
    .head      (q_head)
  );

  assign instr_valid = (q_count != '0);
  assign instruction = instr_valid ? q_head.instr : NOP_INSTR;
  assign pc_out      = instr_valid ? q_head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        inj_rv = 1'b0;

  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  instruction_type instruction;
  logic [31:0]     pc_out;
  logic            fetch_fault;
  logic [31:0]     fault_pc;
  logic            mem_rv = 1'b0;
  logic [31:0]     mem_rd = 32'h0;

  logic            w_req;
  logic [31:0]     w_addr;
  logic            w_rvalid = 1'b0;
  logic [31:0]     w_rdata = 32'h0;
  logic            w_valid;
  instruction_type w_instr;
  logic [31:0]     w_pc;
  logic            w_fault;
  logic [31:0]     w_fpc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rvalid = mem_rv | inj_rv;
  assign imem_rdata  = inj_rv ? 32'hDEAD_BEE0 : mem_rd;

  // Echo memory: rdata is the requested address, one cycle later.
  always @(posedge clk) begin
    mem_rv   <= imem_req;
    mem_rd   <= imem_addr;
    w_rvalid <= w_req;
    w_rdata  <= w_addr;
  end

  fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .pc_out(pc_out),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(1'b1),
    .instruction(w_instr), .pc_out(w_pc),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .fetch_fault(w_fault), .fault_pc(w_fpc)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic        rst, rdy, inj, redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_fault;
    logic [31:0] e_fpc;
  } vec_t;

  localparam int NV = 30;
  vec_t v [NV];

  function automatic vec_t mk(logic rst, logic rdy, logic inj, logic redir,
                              logic [31:0] tgt, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_pc,
                              logic e_fault, logic [31:0] e_fpc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.inj = inj; r.redir = redir; r.tgt = tgt;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc;
    r.e_fault = e_fault; r.e_fpc = e_fpc;
    return r;
  endfunction

  task automatic check(string name, int row, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
    end
  endtask

  initial begin
    //           rst rdy inj red tgt           req addr          vld pc            flt  fpc
    v[0]  = mk(1, 1, 0, 0, 32'h0,    0, 32'h100,  0, 32'h0,    0, 32'h0);
    v[1]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h100,  0, 32'h0,    0, 32'h0);
    v[2]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h104,  0, 32'h0,    0, 32'h0);
    v[3]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h108,  1, 32'h100,  0, 32'h0);
    v[4]  = mk(0, 1, 0, 0, 32'h0,    1, 32'h10C,  1, 32'h104,  0, 32'h0);
    v[5]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h110,  1, 32'h108,  0, 32'h0);
    v[6]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h110,  1, 32'h108,  0, 32'h0);
    v[7]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h110,  1, 32'h108,  0, 32'h0);
    v[8]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h110,  1, 32'h108,  0, 32'h0);
    v[9]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h110,  1, 32'h108,  0, 32'h0);
    v[10] = mk(0, 1, 0, 0, 32'h0,    1, 32'h110,  1, 32'h108,  0, 32'h0);
    v[11] = mk(0, 1, 0, 0, 32'h0,    1, 32'h114,  1, 32'h10C,  0, 32'h0);
    v[12] = mk(0, 1, 0, 0, 32'h0,    1, 32'h118,  1, 32'h110,  0, 32'h0);
    v[13] = mk(0, 1, 0, 1, 32'h2000, 1, 32'h2000, 1, 32'h114,  0, 32'h0);
    v[14] = mk(0, 1, 0, 0, 32'h0,    1, 32'h2004, 0, 32'h0,    0, 32'h0);
    v[15] = mk(0, 1, 0, 0, 32'h0,    1, 32'h2008, 1, 32'h2000, 0, 32'h0);
    v[16] = mk(0, 0, 0, 0, 32'h0,    0, 32'h200C, 1, 32'h2004, 0, 32'h0);
    v[17] = mk(0, 0, 0, 0, 32'h0,    0, 32'h200C, 1, 32'h2004, 0, 32'h0);
    v[18] = mk(0, 0, 0, 1, 32'h3000, 1, 32'h3000, 1, 32'h2004, 0, 32'h0);
    v[19] = mk(0, 0, 0, 0, 32'h0,    1, 32'h3004, 0, 32'h0,    0, 32'h0);
    v[20] = mk(0, 0, 0, 0, 32'h0,    0, 32'h3008, 1, 32'h3000, 0, 32'h0);
    v[21] = mk(0, 1, 0, 1, 32'h4002, !MIS, MIS ? 32'h3008 : 32'h4000,
               1, 32'h3000, 0, 32'h0);
    v[22] = mk(0, 1, 0, 0, 32'h0,    !MIS, MIS ? 32'h3008 : 32'h4004,
               0, 32'h0, MIS, MIS ? 32'h4002 : 32'h0);
    v[23] = mk(0, 1, 0, 1, 32'h4000, 1, 32'h4000, !MIS, MIS ? 32'h0 : 32'h4000,
               MIS, MIS ? 32'h4002 : 32'h0);
    v[24] = mk(0, 1, 0, 0, 32'h0,    1, 32'h4004, 0, 32'h0,    0, 32'h0);
    v[25] = mk(0, 1, 0, 0, 32'h0,    1, 32'h4008, 1, 32'h4000, 0, 32'h0);
    v[26] = mk(1, 1, 0, 0, 32'h0,    0, 32'h100,  1, 32'h4004, 0, 32'h0);
    v[27] = mk(0, 1, 1, 0, 32'h0,    1, 32'h100,  0, 32'h0,    0, 32'h0);
    v[28] = mk(0, 1, 0, 0, 32'h0,    1, 32'h104,  0, 32'h0,    0, 32'h0);
    v[29] = mk(0, 1, 0, 0, 32'h0,    1, 32'h108,  1, 32'h100,  0, 32'h0);

    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset           = v[i].rst;
      instr_ready     = v[i].rdy;
      inj_rv          = v[i].inj;
      redirect_valid  = v[i].redir;
      redirect_target = v[i].tgt;
      #1;
      check("imem_req",    i, 32'(imem_req),    32'(v[i].e_req));
      check("imem_addr",   i, imem_addr,        v[i].e_addr);
      check("instr_valid", i, 32'(instr_valid), 32'(v[i].e_valid));
      check("pc_out",      i, pc_out,           v[i].e_pc);
      check("instruction", i, instruction,
            v[i].e_valid ? v[i].e_pc : NOP_INSTR);
      check("fetch_fault", i, 32'(fetch_fault), 32'(v[i].e_fault));
      check("fault_pc",    i, fault_pc,         v[i].e_fpc);
    end

    // Wraparound: restart both cores and follow the instance at 0xFFFF_FFFC.
    @(negedge clk);
    reset = 1'b1;
    inj_rv = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wrap_req0",  100, 32'(w_req),   32'h1);
    check("wrap_addr0", 100, w_addr,       32'hFFFF_FFFC);
    check("wrap_vld0",  100, 32'(w_valid), 32'h0);
    @(negedge clk); #1;
    check("wrap_req1",  101, 32'(w_req),   32'h1);
    check("wrap_addr1", 101, w_addr,       32'h0000_0000);
    @(negedge clk); #1;
    check("wrap_vld2",  102, 32'(w_valid), 32'h1);
    check("wrap_pc2",   102, w_pc,         32'hFFFF_FFFC);
    check("wrap_ins2",  102, w_instr,      32'hFFFF_FFFC);
    check("wrap_addr2", 102, w_addr,       32'h0000_0004);
    @(negedge clk); #1;
    check("wrap_pc3",   103, w_pc,         32'h0000_0000);
    check("wrap_flt3",  103, 32'(w_fault), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
